// File: rtl/ev_charging_controller_if.sv
// ev_charging_controller_if
// Bundles the measurement inputs and the status outputs of the EV charging
// controller. The master drives the measurements and the slave (the
// controller) reports status back.
interface ev_charging_controller_if;
  logic [15:0] current;
  logic [15:0] voltage;
  logic [15:0] temperature;
  logic        charging;
  logic [3:0]  state;
  logic [3:0]  slot_id;
  logic [3:0]  assigned_slot_id;
  logic [31:0] charging_time;
  logic [7:0]  fault_code;

  modport master (
    output current, voltage, temperature,
    input  charging, state, slot_id, assigned_slot_id, charging_time, fault_code
  );

  modport slave (
    input  current, voltage, temperature,
    output charging, state, slot_id, assigned_slot_id, charging_time, fault_code
  );
endinterface

// File: rtl/ev_charging_controller.sv
// ev_charging_controller
// Session controller for an EV charging point: starts/stops charging from the
// measured voltage, assigns round-robin slots, times each session and latches
// fault causes. Optional macro EVC_TIMEOUT_EN adds a session timeout fault
// after MAX_CHARGE_CYCLES cycles in CHARGING.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | no session; waiting for a plugged-in voltage
//   CHARGING | session active, charging_time counting
//   FULL     | battery at/above V_FULL; waiting for unplug
//   FAULT    | a fault was seen; waits for clean inputs and unplug
module ev_charging_controller #(
  parameter int V_START           = 1000,
  parameter int V_FULL            = 4000,
  parameter int V_MAX             = 5000,
  parameter int I_MAX             = 400,
  parameter int T_MAX             = 80,
  parameter int MAX_CHARGE_CYCLES = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  ev_charging_controller_if.slave  io_evc
);

  localparam logic [15:0] L_V_START = 16'(V_START);
  localparam logic [15:0] L_V_FULL  = 16'(V_FULL);
  localparam logic [15:0] L_V_MAX   = 16'(V_MAX);
  localparam logic [15:0] L_I_MAX   = 16'(I_MAX);
  localparam logic [15:0] L_T_MAX   = 16'(T_MAX);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_CHARGING = 4'b0010,
    ST_FULL     = 4'b0100,
    ST_FAULT    = 4'b1000
  } state_t;

  state_t      r_state;
  logic        r_charging;
  logic [3:0]  r_slot_id;
  logic [3:0]  r_assigned_slot_id;
  logic [31:0] r_charging_time;
  logic [7:0]  r_fault_code;

  logic       w_over_current;
  logic       w_over_temp;
  logic       w_over_volt;
  logic       w_timeout;
  logic [7:0] w_fault_bits;
  logic       w_fault_now;
  logic       w_below_start;
  logic       w_at_full;

  assign w_over_current = io_evc.current > L_I_MAX;
  assign w_over_temp    = io_evc.temperature > L_T_MAX;
  assign w_over_volt    = io_evc.voltage > L_V_MAX;
  assign w_below_start  = io_evc.voltage < L_V_START;
  assign w_at_full      = io_evc.voltage >= L_V_FULL;

`ifdef EVC_TIMEOUT_EN
  // Timeout fires on the last allowed CHARGING cycle so the session spends
  // exactly MAX_CHARGE_CYCLES cycles in CHARGING before FAULT.
  localparam logic [31:0] L_TIMEOUT_LIM = 32'(MAX_CHARGE_CYCLES - 1);
  assign w_timeout = (r_state == ST_CHARGING) && (r_charging_time >= L_TIMEOUT_LIM);
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (MAX_CHARGE_CYCLES == 0);
  assign w_timeout = 1'b0;
`endif

  assign w_fault_bits = {4'b0000, w_timeout, w_over_volt, w_over_temp, w_over_current};
  assign w_fault_now  = |w_fault_bits;

  // Session FSM with registered status outputs; fault overrides all transitions.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state            <= ST_IDLE;
      r_charging         <= 1'b0;
      r_slot_id          <= 4'd0;
      r_assigned_slot_id <= 4'd0;
      r_charging_time    <= 32'd0;
      r_fault_code       <= 8'd0;
    end else begin
      // Every cycle spent in CHARGING counts, including the one it is left on.
      if (r_state == ST_CHARGING && r_charging_time != 32'hFFFF_FFFF) begin
        r_charging_time <= r_charging_time + 32'd1;
      end

      if (w_fault_now) begin
        r_state      <= ST_FAULT;
        r_charging   <= 1'b0;
        // fault_code is zero outside FAULT, so this both loads on entry and
        // accumulates while already faulted.
        r_fault_code <= r_fault_code | w_fault_bits;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_at_full) begin
              r_state <= ST_FULL;
            end else if (!w_below_start) begin
              r_state            <= ST_CHARGING;
              r_charging         <= 1'b1;
              r_assigned_slot_id <= r_slot_id;
              r_slot_id          <= r_slot_id + 4'd1;
              r_charging_time    <= 32'd0;
            end
          end
          ST_CHARGING: begin
            if (w_at_full) begin
              r_state    <= ST_FULL;
              r_charging <= 1'b0;
            end else if (w_below_start) begin
              r_state    <= ST_IDLE;
              r_charging <= 1'b0;
            end
          end
          ST_FULL: begin
            if (w_below_start) begin
              r_state <= ST_IDLE;
            end
          end
          ST_FAULT: begin
            if (w_below_start) begin
              r_state      <= ST_IDLE;
              r_fault_code <= 8'd0;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_charging   <= 1'b0;
            r_fault_code <= 8'd0;
          end
        endcase
      end
    end
  end

  assign io_evc.state            = r_state;
  assign io_evc.charging         = r_charging;
  assign io_evc.slot_id          = r_slot_id;
  assign io_evc.assigned_slot_id = r_assigned_slot_id;
  assign io_evc.charging_time    = r_charging_time;
  assign io_evc.fault_code       = r_fault_code;

endmodule

// File: tb/tb_ev_charging_controller.sv
// tb_ev_charging_controller
// Scoreboard bench: the stimulus process updates a rule-level reference model
// and queues the expected status; a monitor pops and compares after each edge.
module tb_ev_charging_controller;
  localparam int MAXC = 8;
  localparam int S_IDLE = 1, S_CHG = 2, S_FULL = 4, S_FAULT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ev_charging_controller_if ifc ();

  ev_charging_controller #(.MAX_CHARGE_CYCLES(MAXC)) dut (
    .i_clk (clk),
    .i_reset (reset),
    .io_evc (ifc.slave)
  );

  typedef struct {
    int     st;
    int     chg;
    int     slot;
    int     asg;
    longint tm;
    int     code;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int     m_st = S_IDLE;
  int     m_slot = 0;
  int     m_asg = 0;
  longint m_tm = 0;
  int     m_code = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the session rules directly.
  task automatic step(input bit rst, input int cur, input int volt, input int temp);
    int     fc;
    longint nt;
    exp_t   e;
    @(negedge clk);
    reset = rst;
    ifc.current = 16'(cur);
    ifc.voltage = 16'(volt);
    ifc.temperature = 16'(temp);
    if (rst) begin
      m_st = S_IDLE; m_slot = 0; m_asg = 0; m_tm = 0; m_code = 0;
    end else begin
      fc = 0;
      if (cur > 400) fc += 1;
      if (temp > 80) fc += 2;
      if (volt > 5000) fc += 4;
`ifdef EVC_TIMEOUT_EN
      if (m_st == S_CHG && m_tm >= MAXC - 1) fc += 8;
`endif
      nt = m_tm;
      if (m_st == S_CHG && m_tm < 64'hFFFF_FFFF) nt = m_tm + 1;
      if (fc != 0) begin
        m_st = S_FAULT;
        m_code = m_code | fc;
      end else if (m_st == S_IDLE) begin
        if (volt >= 4000) m_st = S_FULL;
        else if (volt >= 1000) begin
          m_st = S_CHG; m_asg = m_slot; m_slot = (m_slot + 1) % 16; nt = 0;
        end
      end else if (m_st == S_CHG) begin
        if (volt >= 4000) m_st = S_FULL;
        else if (volt < 1000) m_st = S_IDLE;
      end else if (m_st == S_FULL) begin
        if (volt < 1000) m_st = S_IDLE;
      end else begin
        if (volt < 1000) begin m_st = S_IDLE; m_code = 0; end
      end
      m_tm = nt;
    end
    e.st = m_st; e.chg = (m_st == S_CHG) ? 1 : 0; e.slot = m_slot;
    e.asg = m_asg; e.tm = m_tm; e.code = m_code;
    q.push_back(e);
  endtask

  task automatic hold(input int n, input int cur, input int volt, input int temp);
    for (int i = 0; i < n; i++) step(1'b0, cur, volt, temp);
  endtask

  // Monitor: compares the DUT status against the queued expectation each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", longint'(ifc.state), longint'(e.st));
        chk("charging", longint'(ifc.charging), longint'(e.chg));
        chk("slot_id", longint'(ifc.slot_id), longint'(e.slot));
        chk("assigned_slot_id", longint'(ifc.assigned_slot_id), longint'(e.asg));
        chk("charging_time", longint'(ifc.charging_time), e.tm);
        chk("fault_code", longint'(ifc.fault_code), longint'(e.code));
      end
    end
  end

  initial begin : stimulus
    int v, c, t, sel;
    reset = 1'b1;
    ifc.current = 16'd500; ifc.voltage = 16'd0; ifc.temperature = 16'd25;

    // reset held with an over-current input, then release
    for (int i = 0; i < 3; i++) step(1'b1, 500, 0, 25);
    hold(3, 20, 0, 25);

    // first session: charge, full, unplug
    hold(4, 20, 1100, 25);
    hold(5, 20, 3500, 25);
    hold(3, 20, 4500, 25);
    hold(2, 20, 0, 25);

    // over-temperature in IDLE, then recovery
    hold(2, 20, 0, 90);
    hold(2, 20, 0, 70);

    // second session
    hold(3, 20, 1200, 25);
    hold(3, 20, 3700, 25);
    hold(2, 20, 4600, 25);
    hold(2, 20, 0, 25);

    // over-current while charging, then a second fault cause stacks
    hold(3, 20, 2000, 25);
    hold(2, 500, 2000, 25);
    hold(1, 500, 2000, 95);
    hold(1, 20, 2000, 25);
    hold(2, 20, 0, 25);

    // sixteen short sessions to wrap the slot pointer
    for (int s = 0; s < 16; s++) begin
      hold(2, 20, 2000, 25);
      hold(1, 20, 0, 25);
    end

    // long session (times out only when the timeout feature is built in)
    hold(12, 20, 2000, 25);
    hold(2, 20, 0, 25);

    // threshold boundaries
    hold(2, 20, 999, 25);
    hold(2, 20, 1000, 25);
    hold(2, 400, 3999, 80);
    hold(1, 401, 3999, 80);
    hold(2, 0, 0, 0);
    hold(2, 0, 4000, 0);
    hold(1, 0, 5000, 0);
    hold(1, 0, 5001, 0);
    hold(1, 0, 5000, 81);
    hold(2, 0, 0, 0);

    // reset in the middle of a session and while faulted
    hold(3, 20, 2000, 25);
    step(1'b1, 20, 2000, 25);
    hold(2, 20, 2000, 25);
    hold(1, 900, 2000, 25);
    step(1'b1, 900, 2000, 25);
    hold(2, 20, 0, 25);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35) v = $urandom_range(0, 999);
      else if (sel < 70) v = $urandom_range(1000, 3999);
      else if (sel < 92) v = $urandom_range(4000, 5000);
      else v = $urandom_range(5001, 6000);
      c = ($urandom_range(0, 99) < 5) ? $urandom_range(401, 1000) : $urandom_range(0, 400);
      t = ($urandom_range(0, 99) < 5) ? $urandom_range(81, 150) : $urandom_range(0, 80);
      step(($urandom_range(0, 99) == 0), c, v, t);
    end
    hold(2, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ev_charging_controller.md
EV_CHARGING_CONTROLLER -- requirements
Module: ev_charging_controller

Interface
REQ-001 Parameter V_START, default 1000: voltage at or above which a charging session starts.
REQ-002 Parameter V_FULL, default 4000: voltage at or above which charging is complete.
REQ-003 Parameter V_MAX, default 5000: over-voltage fault when voltage > V_MAX.
REQ-004 Parameter I_MAX, default 400: over-current fault when current > I_MAX.
REQ-005 Parameter T_MAX, default 80: over-temperature fault when temperature > T_MAX.
REQ-006 Parameter MAX_CHARGE_CYCLES, default 1000: timeout limit; used only when EVC_TIMEOUT_EN is defined.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 current  in  16  measured charge current, unsigned.
REQ-010 voltage  in  16  measured battery/plug voltage, unsigned; 0 = unplugged.
REQ-011 temperature  in  16  measured temperature, unsigned.
REQ-012 charging  out  1  registered; 1 exactly when state = CHARGING.
REQ-013 state  out  4  one-hot state: IDLE=0001, CHARGING=0010, FULL=0100, FAULT=1000.
REQ-014 slot_id  out  4  next slot to be assigned (round-robin pointer).
REQ-015 assigned_slot_id  out  4  slot of the most recently started session.
REQ-016 charging_time  out  32  cycles spent in CHARGING in the current/last session.
REQ-017 fault_code  out  8  bit0 over-current, bit1 over-temperature, bit2 over-voltage, bit3 timeout, bits7:4 = 0.

Function
REQ-018 fault_now = (current > I_MAX) | (temperature > T_MAX) | (voltage > V_MAX) | timeout; all compares are strict and unsigned.
REQ-019 Any state, fault_now = 1 -> FAULT next cycle; fault has priority over every other transition.
REQ-020 IDLE -> CHARGING when V_START <= voltage < V_FULL; IDLE -> FULL when voltage >= V_FULL (no slot assigned, no timer change).
REQ-021 On IDLE->CHARGING: assigned_slot_id <= slot_id; slot_id <= slot_id+1, wrapping 15->0; charging_time <= 0.
REQ-022 CHARGING: charging_time +1 per cycle, saturating at 0xFFFFFFFF; -> FULL when voltage >= V_FULL; -> IDLE when voltage < V_START.
REQ-023 FULL -> IDLE when voltage < V_START; otherwise stay FULL.
REQ-024 In IDLE, FULL and FAULT, charging_time holds its value.
REQ-025 FAULT: fault_code <= fault_code | the new condition bits each cycle (sticky); the entry cycle loads the triggering bits.
REQ-026 FAULT -> IDLE when fault_now = 0 and voltage < V_START; fault_code clears to 0 on that transition.
REQ-027 All outputs are registered and change only on the rising edge of clk.

Reset
REQ-028 When reset = 1 at a clock edge, the block sets state=IDLE, charging=0, slot_id=0, assigned_slot_id=0, charging_time=0 and fault_code=0.
REQ-029 Reset has priority over every fault and input, including mid-session and in FAULT.

Configuration
REQ-030 When the macro EVC_TIMEOUT_EN is defined, timeout = (state == CHARGING) & (charging_time >= MAX_CHARGE_CYCLES-1), which sets fault_code bit3 and causes a transition to FAULT.
REQ-031 When EVC_TIMEOUT_EN is undefined, timeout = 0, fault_code bit3 is always 0 and no timeout logic exists.

Verification
REQ-032 Hold reset=1 with current=500, then release with current=20 and voltage=0 -> state=0001, fault_code=0, all counters 0.
REQ-033 Apply voltage 1100, then 3500, then 4500, then 0 -> state goes 0010 (charging=1, assigned_slot_id=0, slot_id=1, charging_time counts up), then 0100 with charging_time frozen, then 0001.
REQ-034 In IDLE, apply temperature=90 -> FAULT (1000) with fault_code=00000010; then apply temperature=70 with voltage=0 -> IDLE next cycle with fault_code=0.
REQ-035 Run a second session (voltage 1200, then 3700, then 4600, then 0) -> assigned_slot_id=1, slot_id=2, charging_time restarts from 0.
REQ-036 While CHARGING, apply current=500 -> FAULT with fault_code bit0 set and charging=0; also run 16 sessions and confirm slot_id wraps from 15 to 0.
REQ-037 With EVC_TIMEOUT_EN defined and MAX_CHARGE_CYCLES=8, hold voltage=2000 -> FAULT after 8 CHARGING cycles with fault_code=00001000.
